// File: rtl/motor_pkg.sv
// Shared types and helpers for the H-bridge PWM motor controller.
package motor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RAMP,
    RUN,
    DECEL_REV,
    DEADTIME,
    BRAKE
  } motor_state_t;

  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_UP,
    STEP_DOWN
  } ramp_step_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // Duty widths up to 16 bits are supported by this comparison.
  function automatic ramp_step_t ramp_step(input logic [15:0] cur, input logic [15:0] tgt);
    ramp_step = STEP_HOLD;
    if (cur < tgt) ramp_step = STEP_UP;
    else if (cur > tgt) ramp_step = STEP_DOWN;
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler and PWM period counter; boundary marks the last tick of a period.
module pwm_tick_gen #(
  parameter int PRESCALE = 195,
  parameter int DUTY_W   = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              restart,
  output logic              tick,
  output logic              boundary,
  output logic [DUTY_W-1:0] period_cnt
);

  localparam int MAX_DUTY = (1 << DUTY_W) - 1;
  localparam int PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0] presc_cnt;

  assign tick     = (presc_cnt == PS_W'(PRESCALE - 1));
  assign boundary = tick && (period_cnt == DUTY_W'(MAX_DUTY - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt  <= '0;
      period_cnt <= '0;
    end else if (restart) begin
      presc_cnt  <= '0;
      period_cnt <= '0;
    end else if (tick) begin
      presc_cnt  <= '0;
      period_cnt <= boundary ? '0 : period_cnt + 1'b1;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/motor_pwm_ctrl.sv
// H-bridge PWM motor controller with soft ramping, reversal dead time,
// coast and active brake.
module motor_pwm_ctrl
  import motor_pkg::*;
#(
  parameter int DUTY_W          = 4,
  parameter int PRESCALE        = 195,
  parameter int RAMP_PERIODS    = 4,
  parameter int DEADTIME_CYCLES = 1000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              brake,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_duty,
  input  logic              cmd_dir,
  output logic              motor_in1,
  output logic              motor_in2,
  output logic [DUTY_W-1:0] cur_duty,
  output logic              cur_dir,
  output logic              busy
);

  localparam int RC_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam int DT_W = (DEADTIME_CYCLES > 1) ? $clog2(DEADTIME_CYCLES) : 1;

  motor_state_t      state, state_n;
  logic [DUTY_W-1:0] target, target_n, cur_duty_n, pend_duty, pend_duty_n;
  logic              cur_dir_n, pend_dir, pend_dir_n;
  logic [RC_W-1:0]   ramp_cnt, ramp_cnt_n;
  logic [DT_W-1:0]   dead_cnt, dead_cnt_n;
  logic              ready_q, restart, tick_unused, boundary;
  logic [DUTY_W-1:0] period_cnt;
  logic              accept, ramp_due, pwm_on, in1_n, in2_n;
  ramp_step_t        step_dir;

  pwm_tick_gen #(
    .PRESCALE(PRESCALE),
    .DUTY_W  (DUTY_W)
  ) u_tick (
    .clock     (clock),
    .reset_n   (reset_n),
    .restart   (restart),
    .tick      (tick_unused),
    .boundary  (boundary),
    .period_cnt(period_cnt)
  );

  // ready_q keeps the handshake closed while reset is asserted.
  assign cmd_ready = ready_q && enable && !brake &&
                     (state == IDLE || state == RAMP || state == RUN);
  assign accept    = cmd_valid && cmd_ready;
  assign ramp_due  = boundary && (ramp_cnt == RC_W'(RAMP_PERIODS - 1));
  assign step_dir  = ramp_step(16'(cur_duty), 16'(target));
  assign busy      = (state == RAMP) || (state == DECEL_REV) || (state == DEADTIME);
  assign pwm_on    = (period_cnt < cur_duty);

  always_comb begin
    state_n     = state;
    cur_duty_n  = cur_duty;
    target_n    = target;
    cur_dir_n   = cur_dir;
    pend_duty_n = pend_duty;
    pend_dir_n  = pend_dir;
    ramp_cnt_n  = '0;
    dead_cnt_n  = '0;
    restart     = 1'b0;

    if (!enable) begin
      state_n     = IDLE;
      cur_duty_n  = '0;
      target_n    = '0;
      pend_duty_n = '0;
      pend_dir_n  = DIR_FWD;
    end else if (brake) begin
      state_n     = BRAKE;
      cur_duty_n  = '0;
      target_n    = '0;
      pend_duty_n = '0;
      pend_dir_n  = DIR_FWD;
    end else begin
      if (state == RAMP || state == DECEL_REV)
        ramp_cnt_n = boundary ? (ramp_due ? '0 : ramp_cnt + 1'b1) : ramp_cnt;

      case (state)
        IDLE: begin
          cur_duty_n = '0;
          if (accept) begin
            target_n  = cmd_duty;
            cur_dir_n = cmd_dir;
            if (cmd_duty != '0) state_n = RAMP;
          end
        end
        RAMP, RUN: begin
          // An accepted command suppresses that cycle's step so the ramp
          // never overshoots a new target.
          if (accept) begin
            if (cmd_dir == cur_dir) begin
              if (cmd_duty != target) begin
                target_n = cmd_duty;
                state_n  = RAMP;
              end
            end else begin
              pend_dir_n  = cmd_dir;
              pend_duty_n = cmd_duty;
              target_n    = '0;
              state_n     = DECEL_REV;
            end
          end else if (state == RAMP) begin
            if (cur_duty == target) begin
              state_n = (target == '0) ? IDLE : RUN;
            end else if (ramp_due) begin
              case (step_dir)
                STEP_UP:   cur_duty_n = cur_duty + 1'b1;
                STEP_DOWN: cur_duty_n = cur_duty - 1'b1;
                default:   cur_duty_n = cur_duty;
              endcase
            end
          end
        end
        DECEL_REV: begin
          if (cur_duty == '0) state_n = DEADTIME;
          else if (ramp_due && step_dir == STEP_DOWN) cur_duty_n = cur_duty - 1'b1;
        end
        DEADTIME: begin
          if (dead_cnt == DT_W'(DEADTIME_CYCLES - 1)) begin
            cur_dir_n   = pend_dir;
            target_n    = pend_duty;
            pend_duty_n = '0;
            restart     = 1'b1;
            state_n     = (pend_duty == '0) ? IDLE : RAMP;
          end else begin
            dead_cnt_n = dead_cnt + 1'b1;
          end
        end
        BRAKE:   state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Both legs high only ever comes from the brake input itself.
  always_comb begin
    in1_n = 1'b0;
    in2_n = 1'b0;
    if (enable && brake) begin
      in1_n = 1'b1;
      in2_n = 1'b1;
    end else if (enable && (state == RAMP || state == RUN || state == DECEL_REV)) begin
      if (cur_dir == DIR_REV) in2_n = pwm_on;
      else                    in1_n = pwm_on;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cur_duty  <= '0;
      target    <= '0;
      cur_dir   <= DIR_FWD;
      pend_duty <= '0;
      pend_dir  <= DIR_FWD;
      ramp_cnt  <= '0;
      dead_cnt  <= '0;
      ready_q   <= 1'b0;
      motor_in1 <= 1'b0;
      motor_in2 <= 1'b0;
    end else begin
      state     <= state_n;
      cur_duty  <= cur_duty_n;
      target    <= target_n;
      cur_dir   <= cur_dir_n;
      pend_duty <= pend_duty_n;
      pend_dir  <= pend_dir_n;
      ramp_cnt  <= ramp_cnt_n;
      dead_cnt  <= dead_cnt_n;
      ready_q   <= 1'b1;
      motor_in1 <= in1_n;
      motor_in2 <= in2_n;
    end
  end

endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// Directed bench for motor_pwm_ctrl: duty steps are scoreboarded through a
// queue and popped whenever the applied duty changes.
module tb_motor_pwm_ctrl;

  localparam int DUTY_W          = 4;
  localparam int PRESCALE        = 2;
  localparam int RAMP_PERIODS    = 1;
  localparam int DEADTIME_CYCLES = 8;
  localparam int PERIOD_CLKS     = PRESCALE * ((1 << DUTY_W) - 1);

  logic              clock = 1'b0;
  logic              reset_n, enable, brake, cmd_valid, cmd_dir;
  logic [DUTY_W-1:0] cmd_duty;
  logic              cmd_ready, motor_in1, motor_in2, cur_dir, busy;
  logic [DUTY_W-1:0] cur_duty;

  int                assert_count = 0;
  int                fail_count   = 0;
  int                in1_hits     = 0;
  int                in2_hits     = 0;
  int                shoot_through = 0;
  int                last_interval = 0;
  logic [DUTY_W-1:0] exp_q[$];
  logic              brake_at_edge = 1'b0;
  logic              enable_at_edge = 1'b0;

  motor_pwm_ctrl #(
    .DUTY_W         (DUTY_W),
    .PRESCALE       (PRESCALE),
    .RAMP_PERIODS   (RAMP_PERIODS),
    .DEADTIME_CYCLES(DEADTIME_CYCLES)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable   (enable),
    .brake    (brake),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_duty (cmd_duty),
    .cmd_dir  (cmd_dir),
    .motor_in1(motor_in1),
    .motor_in2(motor_in2),
    .cur_duty (cur_duty),
    .cur_dir  (cur_dir),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  // Both H-bridge legs high is legal only when brake&enable were seen at the edge.
  always @(posedge clock) begin
    brake_at_edge  <= brake;
    enable_at_edge <= enable;
  end

  always @(negedge clock) begin
    if (motor_in1 && motor_in2 && !(brake_at_edge && enable_at_edge))
      shoot_through <= shoot_through + 1;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", fail_count);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    assert_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step_clk(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (motor_in1 === 1'b1) in1_hits++;
      if (motor_in2 === 1'b1) in2_hits++;
    end
  endtask

  task automatic apply_stimulus(input logic [DUTY_W-1:0] duty, input logic dir,
                                input string tag);
    cmd_duty  = duty;
    cmd_dir   = dir;
    cmd_valid = 1'b1;
    check_output({tag, "_ready"}, 32'(cmd_ready), 1);
    step_clk(1);
    cmd_valid = 1'b0;
  endtask

  task automatic expect_step(input string tag, input int budget);
    logic [DUTY_W-1:0] prev;
    logic [DUTY_W-1:0] exp_v;
    int cycles;
    prev   = cur_duty;
    cycles = 0;
    do begin
      step_clk(1);
      cycles++;
    end while (cur_duty === prev && cycles < budget);
    last_interval = cycles;
    check_output({tag, "_changed"}, 32'(cur_duty !== prev), 1);
    check_output({tag, "_queued"}, 32'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      check_output(tag, 32'(cur_duty), 32'(exp_v));
    end
  endtask

  task automatic push_range(input int from_v, input int to_v);
    if (from_v <= to_v) for (int v = from_v; v <= to_v; v++) exp_q.push_back(DUTY_W'(v));
    else                for (int v = from_v; v >= to_v; v--) exp_q.push_back(DUTY_W'(v));
  endtask

  initial begin
    int cycles;
    int dark;
    reset_n   = 1'b0;
    enable    = 1'b1;
    brake     = 1'b0;
    cmd_valid = 1'b0;
    cmd_duty  = '0;
    cmd_dir   = 1'b0;

    // Reset state and handshake release.
    step_clk(3);
    check_output("rst_in1", 32'(motor_in1), 0);
    check_output("rst_in2", 32'(motor_in2), 0);
    check_output("rst_duty", 32'(cur_duty), 0);
    check_output("rst_ready", 32'(cmd_ready), 0);
    check_output("rst_busy", 32'(busy), 0);
    reset_n = 1'b1;
    step_clk(1);
    check_output("rel_ready", 32'(cmd_ready), 1);
    check_output("rel_dir", 32'(cur_dir), 0);

    // Soft start to duty 5 forward.
    $display("[TB] soft start");
    in1_hits = 0; in2_hits = 0;
    apply_stimulus(5, 1'b0, "start");
    check_output("start_busy", 32'(busy), 1);
    push_range(1, 5);
    expect_step("start_d1", 40);
    for (int k = 2; k <= 5; k++) begin
      expect_step($sformatf("start_d%0d", k), 40);
      check_output($sformatf("start_gap%0d", k), 32'(last_interval), PERIOD_CLKS);
    end
    check_output("start_in2_quiet", 32'(in2_hits), 0);
    step_clk(2);
    check_output("start_run", 32'(busy), 0);
    in1_hits = 0; in2_hits = 0;
    step_clk(PERIOD_CLKS);
    check_output("d5_in1_high", 32'(in1_hits), 10);
    check_output("d5_in2_high", 32'(in2_hits), 0);

    // Settle at duty 3, then reverse to duty 2.
    $display("[TB] reversal");
    apply_stimulus(3, 1'b0, "down3");
    push_range(4, 3);
    expect_step("down3_d4", 40);
    expect_step("down3_d3", 40);
    step_clk(2);
    check_output("d3_run", 32'(busy), 0);
    in1_hits = 0; in2_hits = 0;
    step_clk(PERIOD_CLKS);
    check_output("d3_in1_high", 32'(in1_hits), 6);
    apply_stimulus(2, 1'b1, "rev");
    check_output("rev_ready_low", 32'(cmd_ready), 0);
    check_output("rev_busy", 32'(busy), 1);
    in1_hits = 0; in2_hits = 0;
    push_range(2, 0);
    expect_step("rev_d2", 40);
    expect_step("rev_d1", 40);
    expect_step("rev_d0", 40);
    check_output("rev_decel_in2_quiet", 32'(in2_hits), 0);
    check_output("rev_decel_old_dir", 32'(cur_dir), 0);
    cycles = 0;
    dark = 0;
    while (cur_dir === 1'b0 && cycles < 40) begin
      step_clk(1);
      cycles++;
      if (motor_in1 !== 1'b0 || motor_in2 !== 1'b0) dark++;
    end
    check_output("rev_dir_flip", 32'(cur_dir), 1);
    check_output("rev_dead_min", 32'(cycles >= DEADTIME_CYCLES), 1);
    check_output("rev_dead_max", 32'(cycles <= DEADTIME_CYCLES + 3), 1);
    check_output("rev_dead_dark", 32'(dark), 0);
    check_output("rev_ready_back", 32'(cmd_ready), 1);
    in1_hits = 0; in2_hits = 0;
    push_range(1, 2);
    expect_step("rev_up1", 40);
    expect_step("rev_up2", 40);
    check_output("rev_in2_pulses", 32'(in2_hits > 0), 1);
    check_output("rev_in1_quiet", 32'(in1_hits), 0);
    step_clk(2);
    check_output("rev_run", 32'(busy), 0);

    // Brake preempts a ramp in progress.
    $display("[TB] brake");
    apply_stimulus(8, 1'b1, "brk_ramp");
    push_range(3, 4);
    expect_step("brk_d3", 40);
    expect_step("brk_d4", 40);
    brake = 1'b1;
    step_clk(1);
    check_output("brk_in1", 32'(motor_in1), 1);
    check_output("brk_in2", 32'(motor_in2), 1);
    check_output("brk_duty", 32'(cur_duty), 0);
    check_output("brk_ready", 32'(cmd_ready), 0);
    step_clk(3);
    check_output("brk_hold", 32'({motor_in1, motor_in2}), 3);
    brake = 1'b0;
    step_clk(1);
    check_output("brk_exit_out", 32'({motor_in1, motor_in2}), 0);
    check_output("brk_exit_ready", 32'(cmd_ready), 1);
    check_output("brk_exit_busy", 32'(busy), 0);

    // Coast overrides brake during dead time.
    $display("[TB] coast priority");
    apply_stimulus(2, 1'b0, "coast_fwd");
    check_output("coast_dir_direct", 32'(cur_dir), 0);
    push_range(1, 2);
    expect_step("coast_up1", 40);
    expect_step("coast_up2", 40);
    step_clk(2);
    apply_stimulus(1, 1'b1, "coast_rev");
    push_range(1, 0);
    expect_step("coast_dn1", 40);
    expect_step("coast_dn0", 40);
    step_clk(2);
    check_output("coast_in_dead", 32'(busy), 1);
    enable = 1'b0;
    brake  = 1'b1;
    step_clk(1);
    check_output("coast_out", 32'({motor_in1, motor_in2}), 0);
    check_output("coast_ready", 32'(cmd_ready), 0);
    check_output("coast_idle", 32'(busy), 0);
    step_clk(12);
    check_output("coast_dir_kept", 32'(cur_dir), 0);
    check_output("coast_out_hold", 32'({motor_in1, motor_in2}), 0);
    enable = 1'b1;
    brake  = 1'b0;
    step_clk(1);
    check_output("coast_reenable_ready", 32'(cmd_ready), 1);
    apply_stimulus(15, 1'b0, "full");
    push_range(1, 15);
    for (int k = 1; k <= 15; k++) expect_step($sformatf("full_d%0d", k), 40);
    step_clk(2);
    check_output("full_run", 32'(busy), 0);
    in1_hits = 0; in2_hits = 0;
    step_clk(PERIOD_CLKS);
    check_output("full_in1_high", 32'(in1_hits), PERIOD_CLKS);
    check_output("full_in2_high", 32'(in2_hits), 0);

    // Asynchronous reset in the middle of a period.
    $display("[TB] mid-period reset");
    #2 reset_n = 1'b0;
    #1;
    check_output("async_in1", 32'(motor_in1), 0);
    check_output("async_in2", 32'(motor_in2), 0);
    check_output("async_duty", 32'(cur_duty), 0);
    check_output("async_ready", 32'(cmd_ready), 0);
    @(negedge clock);
    reset_n = 1'b1;
    step_clk(1);
    check_output("async_rel_ready", 32'(cmd_ready), 1);

    // Same-direction retarget while ramping.
    $display("[TB] retarget");
    apply_stimulus(10, 1'b0, "rt_up");
    push_range(1, 4);
    for (int k = 1; k <= 4; k++) expect_step($sformatf("rt_d%0d", k), 40);
    apply_stimulus(2, 1'b0, "rt_down");
    push_range(3, 2);
    expect_step("rt_back3", 40);
    expect_step("rt_back2", 40);
    step_clk(2);
    check_output("rt_run", 32'(busy), 0);
    check_output("rt_dir", 32'(cur_dir), 0);
    in1_hits = 0; in2_hits = 0;
    step_clk(PERIOD_CLKS);
    check_output("rt_in1_high", 32'(in1_hits), 4);
    check_output("rt_in2_high", 32'(in2_hits), 0);
    step_clk(40);
    check_output("rt_hold", 32'(cur_duty), 2);

    check_output("no_shoot_through", 32'(shoot_through), 0);
    check_output("queue_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/motor_pwm_ctrl.md
Name: motor_pwm_ctrl

Overview:
Parametrised successor to the single-channel, fixed-width PWM motor driver. It accepts duty/direction commands over a valid/ready handshake, typically from the ALU FSM or UART path. It ramps the applied duty toward the target (soft start/stop) and inserts a decelerate-plus-dead-time sequence on direction reversal. It drives an H-bridge in1/in2 pair with coast and brake modes.

Parameters:
DUTY_W, 4, duty resolution in bits; MAX_DUTY = 2^DUTY_W - 1; PWM period = MAX_DUTY ticks
PRESCALE, 195, clock cycles per PWM tick (>=1)
RAMP_PERIODS, 4, PWM periods between ±1 duty steps (>=1)
DEADTIME_CYCLES, 1000, clock cycles both outputs held low between directions (>=1)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  0 = coast: outputs low, duty cleared
brake  in  1  1 = active brake (in1=in2=1)
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_duty  in  DUTY_W  target duty, 0..MAX_DUTY
cmd_dir  in  1  target direction (0 = forward)
motor_in1  out  1  H-bridge input 1 (registered)
motor_in2  out  1  H-bridge input 2 (registered)
cur_duty  out  DUTY_W  currently applied duty
cur_dir  out  1  currently applied direction
busy  out  1  high in RAMP, DECEL_REV, DEADTIME

Behaviour:
- Reset (async, reset_n=0): state IDLE; all counters, cur_duty, target, cur_dir = 0; motor_in1 = motor_in2 = 0; cmd_ready = 0 during reset, 1 at the first clock after release.
- Tick: prescaler counts 0..PRESCALE-1; tick pulses on wrap. Period counter counts 0..MAX_DUTY-1 on ticks; "boundary" = tick while the counter is at MAX_DUTY-1.
- pwm_on = (period_cnt < applied_duty). Duty 0 is constant low; MAX_DUTY is constant high.
- applied_duty updates only at a boundary, so there is no glitch within a period.
- Output map, registered with 1-cycle latency:
  - dir 0: in1 = pwm_on, in2 = 0
  - dir 1: in1 = 0, in2 = pwm_on
  - brake: 1/1
  - in1 = in2 = 1 is never allowed outside BRAKE.
- Priority: !enable > brake > command.
- cmd_ready = 1 in IDLE, RAMP, RUN; 0 in DECEL_REV, DEADTIME, BRAKE, and whenever !enable.
- States:
  - IDLE: cur_duty = 0, outputs low. On accept: latch target and set cur_dir = cmd_dir directly (no dead time, motor stopped). Go to RAMP if cmd_duty > 0; stay in IDLE otherwise.
  - RAMP: every RAMP_PERIODS boundaries, cur_duty moves ±1 toward target. When equal, go to RUN; if equal and 0, go to IDLE.
  - RUN: hold duty.
  - Same-direction accept in RAMP/RUN: update target and go to RAMP; the ramp continues from the present cur_duty.
  - Opposite-direction accept in RAMP/RUN: latch pending dir/duty and go to DECEL_REV.
  - DECEL_REV: ramp toward 0 in the old direction. At 0, go to DEADTIME.
  - DEADTIME: outputs low for DEADTIME_CYCLES clocks. Then cur_dir = pending dir and the period counter restarts. Go to RAMP toward pending duty, or IDLE if pending duty is 0.
  - BRAKE: entered from any state when brake=1 and enable=1. cur_duty and target are cleared; the command is dropped. Exit to IDLE the cycle after brake falls.
- enable=0: next clock, state IDLE; cur_duty, target and pending cleared; outputs low. Takes precedence even during DEADTIME/BRAKE.
- cmd_duty > MAX_DUTY cannot occur (width limited). A duty equal to the current target is accepted; no state change.

Decomposition:
- Package motor_pkg holds:
  - state enum (IDLE, RAMP, RUN, DECEL_REV, DEADTIME, BRAKE)
  - DIR_FWD/DIR_REV constants
  - helper function computing ramp-step direction
- Sub-module pwm_tick_gen: prescaler plus period counter, parameters PRESCALE and DUTY_W. Outputs tick, boundary, period_cnt.
- Top FSM, ramp counter, dead-time counter and output register stay in motor_pwm_ctrl.

Test Plan:
(All tests use PRESCALE=2, DUTY_W=4, RAMP_PERIODS=1, DEADTIME_CYCLES=8.)
1. Reset check: assert reset_n=0 mid-period -> in1 = in2 = 0 and cur_duty = 0 immediately. After release, cmd_ready=1 at the next clock.
2. Soft start: accept duty=5, dir=0 from IDLE -> cur_duty steps 1,2,3,4,5 at successive 30-clock boundaries, then RUN. At duty 5, in1 high 10 of 30 clocks; in2 stays 0.
3. Reversal: in RUN at duty 3, accept dir=1/duty=2 -> cmd_ready=0; duty ramps 2,1,0 on in1. Both outputs then low for 8 clocks, then in2 ramps 1,2 and cmd_ready returns to 1.
4. Brake preemption: brake=1 during RAMP at duty 4 -> next clock in1 = in2 = 1 and cur_duty = 0. Brake=0 -> IDLE with outputs 0.
5. Coast priority: enable=0 with brake=1 during DEADTIME -> outputs 0/0 and state IDLE. Re-enable and issue duty=15 -> duty ramps to 15; at 15, in1 is constantly high.
6. Retarget mid-ramp: during a ramp to 10 at cur_duty 4, accept same-dir duty=2 -> cur_duty 3, 2, then RUN with no dead time.
